// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer and its T-flip-flop bank.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic UP      = 1'b1;
  localparam logic DOWN    = 1'b0;
  localparam logic ONESHOT = 1'b0;
  localparam logic CONT    = 1'b1;

endpackage

// File: rtl/counter_sequencer_tff.sv
// Bank of WIDTH synchronously clocked T flip-flops; each bit flips when its toggle input is high.
module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] toggle,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count ^ toggle;
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer for a T-flip-flop counter: start/stop/hold control, direction, terminal value,
// one-shot or continuous mode, and the per-bit toggle enables that drive the bank.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t             state;
  logic               dir_q;
  logic               mode_q;
  logic [WIDTH-1:0]   limit_q;
  logic [WIDTH-1:0]   toggle;
  logic [WIDTH-1:0]   up_t;
  logic [WIDTH-1:0]   dn_t;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   wrap_val;
  logic [WIDTH-1:0]   term_val;
  logic               at_term;
  logic               up_carry;
  logic               dn_borrow;

  assign load_val = (dir == UP)   ? '0 : limit;
  assign wrap_val = (dir_q == UP) ? '0 : limit_q;
  assign term_val = (dir_q == UP) ? limit_q : '0;
  assign at_term  = (count == term_val);
  assign tc       = (state != IDLE) && at_term;

  // Bit i toggles when all lower bits are ones (up) or all zeros (down).
  always_comb begin
    up_t      = '0;
    dn_t      = '0;
    up_carry  = 1'b1;
    dn_borrow = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      up_t[i]   = up_carry;
      dn_t[i]   = dn_borrow;
      up_carry  = up_carry & count[i];
      dn_borrow = dn_borrow & ~count[i];
    end
  end

  always_comb begin
    toggle = '0;
    case (state)
      IDLE: if (start) toggle = count ^ load_val;
      RUN: begin
        if (!stop && !hold) begin
          if (at_term) begin
            if (mode_q == CONT) toggle = count ^ wrap_val;
          end else begin
            toggle = (dir_q == UP) ? up_t : dn_t;
          end
        end
      end
      default: toggle = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      limit_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            dir_q   <= dir;
            mode_q  <= mode;
            limit_q <= limit;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hold) begin
            state <= HOLD;
          end else if (at_term && mode_q == ONESHOT) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!hold) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .toggle (toggle),
    .count  (count)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench: each clock edge pushes the hand-computed expected outputs; a monitor
// pops and compares them on the following falling edge.
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst, start, stop, hold, dir, mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy, tc, done;

  logic [WIDTH+2:0] exp_q[$];
  string            name_q[$];
  int               checks = 0;
  int               errors = 0;
  logic             finished = 1'b0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .hold  (hold),
    .dir   (dir),
    .mode  (mode),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .tc    (tc),
    .done  (done)
  );

  always @(negedge clk) begin
    logic [WIDTH+2:0] e;
    string            n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ({count, busy, tc, done} !== e) begin
        errors++;
        $display("FAIL %s: got count=%0d busy=%b tc=%b done=%b, expected count=%0d busy=%b tc=%b done=%b",
                 n, count, busy, tc, done, e[WIDTH+2:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    fork
      wait (finished);
      #20000;
    join_any
    disable fork;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within the wait limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Advance one edge and record what the outputs must be after it.
  task automatic tick(input logic [WIDTH-1:0] ec, input logic eb, input logic et,
                      input logic ed, input string nm);
    @(posedge clk);
    #1;
    exp_q.push_back({ec, eb, et, ed});
    name_q.push_back(nm);
  endtask

  task automatic check_reset_state(input string nm);
    checks++;
    if (dut.state !== IDLE || count !== '0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: state=%0d count=%0d busy=%b tc=%b done=%b, expected reset state",
               nm, dut.state, count, busy, tc, done);
    end
  endtask

  task automatic go(input logic d, input logic m, input logic [WIDTH-1:0] l);
    start = 1'b1; dir = d; mode = m; limit = l;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; dir = 1'b0; mode = 1'b0; limit = '0;
    tick(0, 0, 0, 0, "reset_a");
    tick(0, 0, 0, 0, "reset_b");
    check_reset_state("reset_state");
    rst = 1'b0;
    tick(0, 0, 0, 0, "idle");

    // up one-shot, limit 5
    go(1'b1, 1'b0, 4'd5);
    tick(0, 1, 0, 0, "up_load");
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick(4'(i), 1, 0, 0, "up_step");
    tick(5, 1, 1, 0, "up_term");
    tick(5, 0, 0, 1, "up_done");
    tick(5, 0, 0, 0, "up_after");

    // down continuous, limit 3, stopped after 10 edges
    go(1'b0, 1'b1, 4'd3);
    tick(3, 1, 0, 0, "dn_load");
    start = 1'b0;
    tick(2, 1, 0, 0, "dn_2");
    tick(1, 1, 0, 0, "dn_1");
    tick(0, 1, 1, 0, "dn_0");
    tick(3, 1, 0, 0, "dn_wrap");
    tick(2, 1, 0, 0, "dn_2b");
    tick(1, 1, 0, 0, "dn_1b");
    tick(0, 1, 1, 0, "dn_0b");
    tick(3, 1, 0, 0, "dn_wrapb");
    tick(2, 1, 0, 0, "dn_2c");
    stop = 1'b1;
    tick(2, 0, 0, 0, "dn_stop");
    stop = 1'b0;
    tick(2, 0, 0, 0, "dn_frozen");

    // hold at 7, up continuous limit 15, wrap 15 -> 0
    go(1'b1, 1'b1, 4'd15);
    tick(0, 1, 0, 0, "hold_load");
    start = 1'b0;
    for (int i = 1; i <= 7; i++) tick(4'(i), 1, 0, 0, "hold_run");
    hold = 1'b1;
    tick(7, 1, 0, 0, "hold_1");
    tick(7, 1, 0, 0, "hold_2");
    tick(7, 1, 0, 0, "hold_3");
    hold = 1'b0;
    tick(7, 1, 0, 0, "hold_release");
    for (int i = 8; i <= 14; i++) tick(4'(i), 1, 0, 0, "hold_resume");
    tick(15, 1, 1, 0, "hold_term");
    tick(0, 1, 0, 0, "hold_wrap");
    tick(1, 1, 0, 0, "hold_after_wrap");
    stop = 1'b1;
    tick(1, 0, 0, 0, "hold_stop");
    stop = 1'b0;

    // stop and hold together
    go(1'b1, 1'b1, 4'd9);
    tick(0, 1, 0, 0, "sh_load");
    start = 1'b0;
    tick(1, 1, 0, 0, "sh_1");
    tick(2, 1, 0, 0, "sh_2");
    stop = 1'b1; hold = 1'b1;
    tick(2, 0, 0, 0, "sh_both");
    stop = 1'b0; hold = 1'b0;
    tick(2, 0, 0, 0, "sh_idle");

    // start while busy, dir/limit changed mid-run: ignored
    go(1'b1, 1'b0, 4'd4);
    tick(0, 1, 0, 0, "busy_load");
    dir = 1'b0; limit = 4'd9; mode = 1'b1;
    tick(1, 1, 0, 0, "busy_restart_1");
    tick(2, 1, 0, 0, "busy_restart_2");
    start = 1'b0;
    tick(3, 1, 0, 0, "busy_3");
    tick(4, 1, 1, 0, "busy_term");
    tick(4, 0, 0, 1, "busy_done");
    tick(4, 0, 0, 0, "busy_after");

    // limit 0 one-shot
    go(1'b1, 1'b0, 4'd0);
    tick(0, 1, 1, 0, "zero_load");
    start = 1'b0;
    tick(0, 0, 0, 1, "zero_done");
    tick(0, 0, 0, 0, "zero_after");

    // start with stop in IDLE: start wins
    go(1'b1, 1'b1, 4'd2);
    stop = 1'b1;
    tick(0, 1, 0, 0, "ss_load");
    start = 1'b0; stop = 1'b0;
    tick(1, 1, 0, 0, "ss_1");
    tick(2, 1, 1, 0, "ss_term");
    tick(0, 1, 0, 0, "ss_wrap");
    stop = 1'b1;
    tick(0, 0, 0, 0, "ss_stop");
    stop = 1'b0;

    // reset mid-sequence drops a pending done
    go(1'b1, 1'b0, 4'd3);
    tick(0, 1, 0, 0, "rst_load");
    start = 1'b0;
    tick(1, 1, 0, 0, "rst_1");
    tick(2, 1, 0, 0, "rst_2");
    tick(3, 1, 1, 0, "rst_term");
    rst = 1'b1;
    tick(0, 0, 0, 0, "rst_mid_a");
    tick(0, 0, 0, 0, "rst_mid_b");
    check_reset_state("rst_mid_state");
    rst = 1'b0;
    tick(0, 0, 0, 0, "rst_idle");

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    finished = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Control block for the team's T-flip-flop counters: sequences a WIDTH-bit counter built from a bank of synchronously clocked T flip-flops, computing the per-bit toggle enables. Adds start/stop/hold control, up/down direction, a programmable terminal value, one-shot or continuous mode, and terminal-count/done flags. It replaces free-running ripple counting wherever software-visible, cycle-exact sequencing is needed.

## Interface
- WIDTH, 4, counter width in bits (2..16)
- clk  in  1  clock; all flops on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  start request; honoured only in IDLE
- stop  in  1  abort request; honoured in RUN or HOLD
- hold  in  1  level; while high in RUN the count freezes
- dir  in  1  1 = count up, 0 = count down; sampled at start
- mode  in  1  0 = one-shot, 1 = continuous wrap; sampled at start
- limit  in  WIDTH  terminal value; sampled at start
- count  out  WIDTH  current count (T-ff bank outputs)
- busy  out  1  high in RUN or HOLD
- tc  out  1  high in any RUN/HOLD cycle where count equals terminal value
- done  out  1  one-cycle pulse when a one-shot sequence completes

## Operation
- States: IDLE, RUN, HOLD. Reset: state IDLE, count 0, busy 0, tc 0, done 0; latched dir/mode/limit cleared to 0.
- IDLE: count holds its value. start=1 -> RUN; dir, mode and limit latched in the same edge; count loaded with the start value: 0 when up, limit when down.
- RUN: one step per cycle. Up: 0,1,…,limit. Down: limit,…,0. Terminal value: limit when up, 0 when down.
- Step at terminal, continuous: wrap to the start value (up: limit -> 0; down: 0 -> limit).
- Step at terminal, one-shot: -> IDLE; count keeps its terminal value; done pulses for one cycle.
- hold=1 in RUN -> HOLD; count frozen. hold=0 in HOLD -> RUN; stepping resumes on the next edge.
- stop=1 in RUN or HOLD -> IDLE; count retained; no done pulse.
- Input priority in the same cycle: rst > stop > hold > step. start is ignored outside IDLE.
- start together with stop in IDLE: start wins, because stop has no effect in IDLE.
- limit=0: the count stays 0; tc is high in every RUN/HOLD cycle. One-shot: done one cycle after entering RUN. Continuous: runs at 0 until stop.
- Toggle rules (T-ff inputs). Up step: bit i toggles iff count[i-1:0] is all ones. Down step: bit i toggles iff count[i-1:0] is all zeros. Bit 0 always toggles on a step.
- Load or wrap: toggle vector = count XOR target. Frozen (IDLE/HOLD): toggle vector = 0.
- Width: limit is unsigned WIDTH bits. No count value above limit is ever produced.

## Timing
- start sampled at edge N: busy=1 and count=start value after N. First step lands at edge N+1.
- Up, limit=L, one-shot: count=L after edge N+L. tc high during the cycle after edge N+L. State is IDLE and done=1 after edge N+L+1. done=0 after edge N+L+2.
- Continuous: period is limit+1 cycles; tc high for one cycle per period, unless held.
- count, busy, done: registered. tc: decoded from registered state and count only; no combinational input-to-output path.
- rst mid-sequence: all outputs at reset values after that edge. A pending done is dropped.

## Structure
- Shared package: state enum (IDLE, RUN, HOLD); direction constants UP=1, DOWN=0; mode constants ONESHOT=0, CONT=1.
- One sub-module, tff_bank: WIDTH T flip-flops on clk with a synchronous active-high reset to 0. It takes the toggle vector as input and drives count.
- Controller: FSM, latched config registers, toggle-vector generation, tc/done decode.
- Roughly 150–250 lines of RTL in total.

## Test plan
- Reset: assert rst 2 cycles mid-count -> count=0, busy=0, tc=0, done=0, state IDLE.
- Up one-shot, WIDTH=4, limit=5: start pulse -> count 0,1,2,3,4,5; tc high only at 5; done pulse one cycle later; busy falls with done; count stays 5.
- Down continuous, limit=3: count 3,2,1,0,3,2…; tc at every 0.
- After 10 cycles assert stop -> IDLE next edge, count frozen, done never asserted.
- Hold: up continuous, limit=15; hold high 3 cycles at count=7 -> count 7 for those cycles, then 8. 15 -> 0 wrap checked.
- Priority and edge cases, each in its own sequence:
  - stop and hold together -> IDLE.
  - start while busy -> ignored, count unaffected.
  - limit=0 one-shot -> done one cycle after start, count=0.
  - Change dir/limit mid-run -> no effect until next start.
